// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver core.
package uart_prog_loader_pkg;

  typedef enum logic [3:0] {
    IDLE, HDR, TGT, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
  } ldr_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] TGT_IMEM  = 8'h00;
  localparam logic [7:0] TGT_DMEM  = 8'h01;

  // Clock cycles per 16x oversampling tick, rounded to nearest.
  function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud * 8) / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling tick, mid-bit sampler.
module uart_rx_core
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 23_000_000,
  parameter int unsigned BAUD   = 128_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       frame_err_o
);

  localparam int unsigned DIV_RAW = tick_div(CLK_HZ, BAUD);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int          DIV_W   = $clog2(DIV + 1);

  logic             sync1_q, sync2_q, prev_q;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  rx_state_e        rstate_q, rstate_d;
  logic [3:0]       smp_q, smp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      div_q    <= '0;
      rstate_q <= RX_IDLE;
      smp_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      div_q    <= tick ? '0 : div_q + DIV_W'(1);
      rstate_q <= rstate_d;
      smp_q    <= smp_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  // A start needs a real falling edge, so a line held low after a bad stop bit is not re-read.
  always_comb begin
    rstate_d = rstate_q;
    smp_d    = smp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    case (rstate_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          rstate_d = RX_START;
          smp_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (smp_q == 4'd7) begin
            smp_d    = '0;
            bit_d    = '0;
            rstate_d = sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          smp_d = smp_q + 4'd1;
          if (smp_q == 4'd15) begin
            shift_d = {sync2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) rstate_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          smp_d = smp_q + 4'd1;
          if (smp_q == 4'd15) begin
            rstate_d = RX_IDLE;
            if (sync2_q) begin
              valid_d = 1'b1;
              byte_d  = shift_q;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
      default: rstate_d = RX_IDLE;
    endcase
  end

  assign rx_valid_o  = valid_q;
  assign rx_byte_o   = byte_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: parses a framed UART image, writes 32-bit LE words to imem/dmem, gates CPU reset.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 23_000_000,
  parameter int unsigned BAUD        = 128_000,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = 2_300_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  input  logic              start_pg,
  output logic              upg_wen_o,
  output logic              upg_sel_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              cpu_hold_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam int          TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk         (clk),
    .rst_n       (rst),
    .rx_i        (uart_rx),
    .rx_valid_o  (rx_valid),
    .rx_byte_o   (rx_byte),
    .frame_err_o (frame_err)
  );

  ldr_state_e        state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       widx_q, widx_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              in_frame;
  logic              go_err;
  logic [15:0]       cnt_rx;

  assign in_frame = state_q inside {TGT, LEN_HI, LEN_LO, DATA, CSUM};
  assign cnt_rx   = {cnt_q[15:8], rx_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
      widx_q  <= '0;
      csum_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      csum_q  <= csum_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    wen_d   = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    csum_d  = csum_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    go_err  = 1'b0;
    to_d    = (rx_valid || !in_frame) ? '0 : to_q + TO_W'(1);
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_pg) begin
          state_d = HDR;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          adr_d   = '0;
          csum_d  = '0;
        end
      end
      HDR: begin
        if (rx_valid && rx_byte == SYNC_BYTE) state_d = TGT;
      end
      TGT: begin
        if (rx_valid) begin
          if (rx_byte == TGT_IMEM || rx_byte == TGT_DMEM) begin
            sel_d   = rx_byte[0];
            csum_d  = csum_q ^ rx_byte;
            state_d = LEN_HI;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          cnt_d   = {rx_byte, cnt_q[7:0]};
          csum_d  = csum_q ^ rx_byte;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          cnt_d  = cnt_rx;
          csum_d = csum_q ^ rx_byte;
          widx_d = '0;
          bidx_d = '0;
          if ({16'd0, cnt_rx} > MAX_WORDS) go_err = 1'b1;
          else if (cnt_rx == 16'd0)        state_d = CSUM;
          else                             state_d = DATA;
        end
      end
      DATA: begin
        // Bytes shift in from the top, so after three bytes word_q holds {b2,b1,b0}.
        if (rx_valid) begin
          csum_d = csum_q ^ rx_byte;
          bidx_d = bidx_q + 2'd1;
          word_d = {rx_byte, word_q[23:8]};
          if (bidx_q == 2'd3) begin
            wen_d  = 1'b1;
            adr_d  = widx_q[ADDR_W-1:0];
            dat_d  = {rx_byte, word_q};
            widx_d = widx_q + 16'd1;
            if (widx_q + 16'd1 == cnt_q) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_frame && (frame_err || (!rx_valid && to_q == TO_W'(TIMEOUT_CYC - 1)))) go_err = 1'b1;
    if (go_err) begin
      state_d = ERR;
      err_d   = 1'b1;
      done_d  = 1'b0;
      hold_d  = 1'b1;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_sel_o  = sel_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign cpu_hold_o = hold_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: table of frames plus hand-written error, timeout, reset and baud cases.
`timescale 1ns/1ps
module tb_uart_prog_loader;

  localparam int unsigned CLK_HZ      = 3_200_000;
  localparam int unsigned BAUD        = 100_000;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned TIMEOUT_CYC = 1500;
  // 10 ns clock, 32 clocks per bit
  localparam real BIT_NS = 320.0;

  logic              clk;
  logic              rst;
  logic              uart_rx;
  logic              start_pg;
  logic              upg_wen_o;
  logic              upg_sel_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              cpu_hold_o;
  logic              upg_done_o;
  logic              upg_err_o;

  uart_prog_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .start_pg   (start_pg),
    .upg_wen_o  (upg_wen_o),
    .upg_sel_o  (upg_sel_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .cpu_hold_o (cpu_hold_o),
    .upg_done_o (upg_done_o),
    .upg_err_o  (upg_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
    logic [31:0]       lat;
  } wr_t;

  typedef struct packed {
    logic [127:0] b;
    logic [4:0]   nb;
    logic         add_cs;
    logic [7:0]   cs_x;
    logic         e_done;
    logic         e_sel;
    logic [1:0]   nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  vec_t tbl[7];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_rxv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe with its distance from the most recent received byte.
  always @(negedge clk) begin
    if (upg_wen_o) got_q.push_back({upg_sel_o, upg_adr_o, upg_dat_o, 32'(cyc - last_rxv)});
    if (dut.rx_valid) last_rxv = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input real bit_ns);
    uart_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #(bit_ns);
    end
    uart_rx = stop_v;
    #(bit_ns);
    uart_rx = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start_pg = 1'b1;
    @(negedge clk) start_pg = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    wr_t g, e;
    chk({tag, "_wr_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_wr_sel"}, 32'(g.sel), 32'(e.sel));
      chk({tag, "_wr_adr"}, 32'(g.adr), 32'(e.adr));
      chk({tag, "_wr_dat"}, g.dat, e.dat);
      chk({tag, "_wr_lat"}, g.lat, e.lat);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input real bit_ns, input string tag);
    logic [7:0] bt;
    logic [7:0] cs;
    bit         seen;
    pulse_start();
    chk({tag, "_hold_start"}, 32'(cpu_hold_o), 32'd1);
    chk({tag, "_done_start"}, 32'(upg_done_o), 32'd0);
    chk({tag, "_err_start"},  32'(upg_err_o),  32'd0);
    for (int k = 0; k < int'(v.nwr); k++)
      exp_q.push_back({v.e_sel, ADDR_W'(k), (k == 0) ? v.w0 : v.w1, 32'd1});
    cs   = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < int'(v.nb); i++) begin
      bt = v.b[127 - 8*i -: 8];
      if (seen) cs = cs ^ bt;
      if (bt == 8'hA5) seen = 1'b1;
      send_byte(bt, 1'b1, bit_ns);
    end
    if (v.add_cs) send_byte(cs ^ v.cs_x, 1'b1, bit_ns);
    repeat (4) @(negedge clk);
    chk({tag, "_done"}, 32'(upg_done_o), 32'(v.e_done));
    chk({tag, "_err"},  32'(upg_err_o),  32'(!v.e_done));
    chk({tag, "_hold"}, 32'(cpu_hold_o), 32'(!v.e_done));
    if (v.e_done) chk({tag, "_sel"}, 32'(upg_sel_o), 32'(v.e_sel));
    check_writes(tag);
  endtask

  initial begin
    int n;
    int t0;
    //            bytes (MSB first)                           nb   cs  csx  done sel nwr w0            w1
    tbl[0] = {128'hA5000002_78563412_EFBEADDE_00000000, 5'd12, 1'b1, 8'h00, 1'b1, 1'b0, 2'd2, 32'h12345678, 32'hDEADBEEF};
    tbl[1] = {128'hA5000002_78563412_EFBEADDE_00000000, 5'd12, 1'b1, 8'h01, 1'b0, 1'b0, 2'd2, 32'h12345678, 32'hDEADBEEF};
    tbl[2] = {128'hA5000002_78563412_EFBEADDE_00000000, 5'd12, 1'b1, 8'h00, 1'b1, 1'b0, 2'd2, 32'h12345678, 32'hDEADBEEF};
    tbl[3] = {128'h00FFA501_00011122_33440000_00000000, 5'd10, 1'b1, 8'h00, 1'b1, 1'b1, 2'd1, 32'h44332211, 32'h0};
    tbl[4] = {128'hA5020000_00000000_00000000_00000000, 5'd2,  1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0};
    tbl[5] = {128'hA5010000_00000000_00000000_00000000, 5'd4,  1'b1, 8'h00, 1'b1, 1'b1, 2'd0, 32'h0,        32'h0};
    tbl[6] = {128'hA5000011_00000000_00000000_00000000, 5'd4,  1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0};

    rst      = 1'b0;
    uart_rx  = 1'b1;
    start_pg = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_wen",  32'(upg_wen_o),  32'd0);
    chk("rst_sel",  32'(upg_sel_o),  32'd0);
    chk("rst_adr",  32'(upg_adr_o),  32'd0);
    chk("rst_dat",  upg_dat_o,       32'd0);
    chk("rst_hold", 32'(cpu_hold_o), 32'd0);
    chk("rst_done", 32'(upg_done_o), 32'd0);
    chk("rst_err",  32'(upg_err_o),  32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    for (int t = 0; t < 7; t++) run_vec(tbl[t], BIT_NS, $sformatf("vec%0d", t));

    // Stop bit of the sixth byte held low.
    pulse_start();
    send_byte(8'hA5, 1'b1, BIT_NS);
    send_byte(8'h00, 1'b1, BIT_NS);
    send_byte(8'h00, 1'b1, BIT_NS);
    send_byte(8'h02, 1'b1, BIT_NS);
    send_byte(8'h78, 1'b1, BIT_NS);
    send_byte(8'h56, 1'b0, BIT_NS);
    #(BIT_NS * 3);
    chk("stoperr_err",  32'(upg_err_o),  32'd1);
    chk("stoperr_done", 32'(upg_done_o), 32'd0);
    chk("stoperr_hold", 32'(cpu_hold_o), 32'd1);
    check_writes("stoperr");

    // Line goes quiet after the length field.
    pulse_start();
    send_byte(8'hA5, 1'b1, BIT_NS);
    send_byte(8'h00, 1'b1, BIT_NS);
    send_byte(8'h00, 1'b1, BIT_NS);
    send_byte(8'h01, 1'b1, BIT_NS);
    t0 = last_rxv;
    chk("timeout_early", 32'(upg_err_o), 32'd0);
    n = 0;
    while (!upg_err_o && n < int'(TIMEOUT_CYC) * 2) begin
      @(negedge clk);
      n++;
    end
    // err rises the cycle after the TIMEOUT_CYC-th idle cycle following the last byte
    chk("timeout_err",    32'(upg_err_o),  32'd1);
    chk("timeout_cycles", 32'(cyc - t0),   32'(TIMEOUT_CYC + 1));
    chk("timeout_hold",   32'(cpu_hold_o), 32'd1);
    check_writes("timeout");

    // Reset asserted in the middle of the second data word.
    pulse_start();
    exp_q.push_back({1'b0, ADDR_W'(0), 32'h12345678, 32'd1});
    send_byte(8'hA5, 1'b1, BIT_NS);
    send_byte(8'h00, 1'b1, BIT_NS);
    send_byte(8'h00, 1'b1, BIT_NS);
    send_byte(8'h02, 1'b1, BIT_NS);
    send_byte(8'h78, 1'b1, BIT_NS);
    send_byte(8'h56, 1'b1, BIT_NS);
    send_byte(8'h34, 1'b1, BIT_NS);
    send_byte(8'h12, 1'b1, BIT_NS);
    send_byte(8'hEF, 1'b1, BIT_NS);
    @(negedge clk);
    chk("midrst_hold_before", 32'(cpu_hold_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_wen",  32'(upg_wen_o),  32'd0);
    chk("midrst_adr",  32'(upg_adr_o),  32'd0);
    chk("midrst_dat",  upg_dat_o,       32'd0);
    chk("midrst_hold", 32'(cpu_hold_o), 32'd0);
    chk("midrst_done", 32'(upg_done_o), 32'd0);
    chk("midrst_err",  32'(upg_err_o),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_idle_hold", 32'(cpu_hold_o), 32'd0);
    chk("midrst_idle_done", 32'(upg_done_o), 32'd0);
    check_writes("midrst");

    // Sender clock off by +/-2 %.
    run_vec(tbl[0], BIT_NS * 1.02, "baud_slow");
    run_vec(tbl[3], BIT_NS * 0.98, "baud_fast");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
